// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (shift-add / restoring divide).
// Fixed latency of 34 edges from start acceptance to done.
// Optional build macro MULDIV_EARLY_OUT_EN: trivially-known results (multiply by
// zero, divide by zero, signed overflow) skip the iteration and finish after 2 edges.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t            state_q;
  logic [2:0]        op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q;     // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [XLEN-1:0]   opnd_q;    // mul: |A| added per step; div: |B| subtracted per step
  logic              neg_q;     // product / quotient must be negated
  logic              rneg_q;    // remainder takes dividend sign
  logic              bzero_q;
  logic [4:0]        rd_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;

  logic              a_signed, b_signed, a_neg, b_neg, b_zero, early_d;
  logic [XLEN-1:0]   a_mag, b_mag, opnd_init_d;
  logic [2*XLEN-1:0] acc_init_d;

  // Operand intake: magnitudes, sign flags and the initial accumulator.
  always_comb begin
    a_signed    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg       = a_signed && rs1_val[XLEN-1];
    b_neg       = b_signed && rs2_val[XLEN-1];
    a_mag       = a_neg ? -rs1_val : rs1_val;
    b_mag       = b_neg ? -rs2_val : rs2_val;
    b_zero      = (rs2_val == '0);
    opnd_init_d = funct3[2] ? b_mag : a_mag;
    acc_init_d  = funct3[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
    early_d     = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
    // Preload the accumulator with the magnitude-form answer; FIN fixup is shared.
    if (funct3[2]) begin
      if (b_zero) begin
        early_d    = 1'b1;
        acc_init_d = {a_mag, {XLEN{1'b1}}};
      end else if (!funct3[0] && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (rs2_val == {XLEN{1'b1}})) begin
        early_d    = 1'b1;
        acc_init_d = {{XLEN{1'b0}}, a_mag};
      end
    end else if (b_zero || (rs1_val == '0)) begin
      early_d    = 1'b1;
      acc_init_d = '0;
    end
`endif
  end

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] acc_step;

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge   = (div_sh >= {1'b0, opnd_q});
    // When div_ge holds the true difference is below |B|, so modulo-2^XLEN is exact.
    div_sub  = div_sh[XLEN-1:0] - opnd_q;
    acc_step = op_q[2] ? {(div_ge ? div_sub : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge}
                       : {mul_sum, acc_q[XLEN-1:1]};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fin_d;

  // Sign correction and result select; divide-by-zero quotient forced to all ones.
  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = bzero_q ? {XLEN{1'b1}}
                       : (neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
    rem_fix  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 fin_d = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_d = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_d = quot_fix;
      default:                fin_d = rem_fix;
    endcase
  end

  // Control FSM with registered busy/done/result/rd_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
      rd_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !kill) begin
            op_q    <= funct3;
            rd_q    <= rd_in;
            acc_q   <= acc_init_d;
            opnd_q  <= opnd_init_d;
            neg_q   <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            bzero_q <= b_zero;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= early_d ? S_FIN : S_CALC;
          end
        end
        S_CALC: begin
          if (kill) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_q <= S_FIN;
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (!kill) begin
            result_q <= fin_d;
            rd_out_q <= rd_q;
            done_q   <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule
